// File: rtl/hdmi_src_switch.sv
// Frame-synchronous two-source AXI4-Stream video switch in front of hdmi_tx.
// Source changes only happen at end of frame, and the block flags malformed line/frame framing.
module hdmi_src_switch #(
    parameter int DATA_WIDTH = 32,
    parameter int X_RES      = 1920,
    parameter int Y_RES      = 1080
) (
    input  logic                  px_clk_i,
    input  logic                  rst_i,
    input  logic                  sel_i,

    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    input  logic                  s0_tuser,
    input  logic                  s0_tlast,
    output logic                  s0_tready,

    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    input  logic                  s1_tuser,
    input  logic                  s1_tlast,
    output logic                  s1_tready,

    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tuser,
    output logic                  m_tlast,
    input  logic                  m_tready,

    output logic                  active_o,
    output logic                  switch_pending_o,
    output logic                  frame_err_o
);

    localparam int PX_W = (X_RES > 1) ? $clog2(X_RES) : 1;
    localparam int LN_W = (Y_RES > 1) ? $clog2(Y_RES) : 1;
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(X_RES - 1);
    localparam logic [LN_W-1:0] LN_LAST = LN_W'(Y_RES - 1);

    typedef enum logic {
        SYNC,
        PASS
    } state_t;

    state_t          state;
    logic            sel_r;
    logic [PX_W-1:0] px_cnt;
    logic [LN_W-1:0] line_cnt;

    state_t          eff_state;
    logic            eff_active;

    logic [DATA_WIDTH-1:0] act_tdata;
    logic            act_tvalid;
    logic            act_tuser;
    logic            act_tlast;
    logic            act_tready;

    logic            m_acc;
    logic            sof_acc;
    logic            eol_acc;
    logic            eof_acc;
    logic            err_sof;
    logic            err_eol;
    logic [PX_W-1:0] px_base;
    logic [LN_W-1:0] ln_base;

    // While reset is held the stream side already behaves as SYNC with s0 selected.
    always_comb begin
        eff_state  = rst_i ? SYNC : state;
        eff_active = rst_i ? 1'b0 : active_o;
    end

    always_comb begin
        if (eff_active) begin
            act_tdata  = s1_tdata;
            act_tvalid = s1_tvalid;
            act_tuser  = s1_tuser;
            act_tlast  = s1_tlast;
        end else begin
            act_tdata  = s0_tdata;
            act_tvalid = s0_tvalid;
            act_tuser  = s0_tuser;
            act_tlast  = s0_tlast;
        end
    end

    // In SYNC everything up to the next SOF is swallowed; a parked source is drained
    // except for its SOF beat, which is held so the switch can start on it immediately.
    always_comb begin
        act_tready = m_tready;
        m_tvalid   = act_tvalid;
        if (eff_state == SYNC && !act_tuser) begin
            act_tready = 1'b1;
            m_tvalid   = 1'b0;
        end
        m_tdata = act_tdata;
        m_tuser = act_tuser;
        m_tlast = act_tlast;

        s0_tready = eff_active ? !s0_tuser : act_tready;
        s1_tready = eff_active ? act_tready : !s1_tuser;
    end

    // An accepted SOF restarts position from (0,0) before the tlast/EOF tests apply.
    always_comb begin
        m_acc   = m_tvalid & m_tready;
        sof_acc = m_acc & act_tuser;
        eol_acc = m_acc & act_tlast;
        px_base = sof_acc ? '0 : px_cnt;
        ln_base = sof_acc ? '0 : line_cnt;
        err_sof = sof_acc && (state == PASS) && ((px_cnt != '0) || (line_cnt != '0));
        err_eol = eol_acc && (px_base != PX_LAST);
        eof_acc = eol_acc && (ln_base == LN_LAST);
    end

    always_ff @(posedge px_clk_i) begin
        if (rst_i) begin
            state            <= SYNC;
            active_o         <= 1'b0;
            sel_r            <= 1'b0;
            px_cnt           <= '0;
            line_cnt         <= '0;
            frame_err_o      <= 1'b0;
            switch_pending_o <= 1'b0;
        end else begin
            sel_r            <= sel_i;
            switch_pending_o <= (sel_r != active_o);
            frame_err_o      <= err_sof | err_eol;

            if (m_acc) begin
                if (eol_acc) begin
                    px_cnt   <= '0;
                    line_cnt <= (ln_base == LN_LAST) ? '0 : ln_base + LN_W'(1);
                end else begin
                    px_cnt   <= px_base + PX_W'(1);
                    line_cnt <= ln_base;
                end

                if (eof_acc) begin
                    state    <= SYNC;
                    active_o <= sel_r;
                end else begin
                    state    <= PASS;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_src_switch.sv
// Scoreboard bench for hdmi_src_switch with a 4x2 frame geometry.
// Source queues feed the DUT; expected output beats are queued alongside and checked by a monitor.
module tb_hdmi_src_switch;

    localparam int DW = 32;
    localparam int XR = 4;
    localparam int YR = 2;

    logic          px_clk_i = 1'b0;
    logic          rst_i    = 1'b1;
    logic          sel_i    = 1'b0;
    logic [DW-1:0] s0_tdata = '0;
    logic          s0_tvalid = 1'b0;
    logic          s0_tuser = 1'b0;
    logic          s0_tlast = 1'b0;
    logic          s0_tready;
    logic [DW-1:0] s1_tdata = '0;
    logic          s1_tvalid = 1'b0;
    logic          s1_tuser = 1'b0;
    logic          s1_tlast = 1'b0;
    logic          s1_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tuser;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic          active_o;
    logic          switch_pending_o;
    logic          frame_err_o;

    hdmi_src_switch #(.DATA_WIDTH(DW), .X_RES(XR), .Y_RES(YR)) dut (
        .px_clk_i         (px_clk_i),
        .rst_i            (rst_i),
        .sel_i            (sel_i),
        .s0_tdata         (s0_tdata),
        .s0_tvalid        (s0_tvalid),
        .s0_tuser         (s0_tuser),
        .s0_tlast         (s0_tlast),
        .s0_tready        (s0_tready),
        .s1_tdata         (s1_tdata),
        .s1_tvalid        (s1_tvalid),
        .s1_tuser         (s1_tuser),
        .s1_tlast         (s1_tlast),
        .s1_tready        (s1_tready),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tuser          (m_tuser),
        .m_tlast          (m_tlast),
        .m_tready         (m_tready),
        .active_o         (active_o),
        .switch_pending_o (switch_pending_o),
        .frame_err_o      (frame_err_o)
    );

    always #5 px_clk_i = ~px_clk_i;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    beat_t s0_q[$];
    beat_t s1_q[$];
    beat_t exp_q[$];
    beat_t mon_e;

    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   err_seen  = 0;
    int   exp_err   = 0;
    int   out_beats = 0;
    logic acc0      = 1'b0;
    logic acc1      = 1'b0;
    bit   bp_rand   = 1'b0;
    bit   park_chk  = 1'b0;

    // Handshakes are sampled mid-cycle; the queues advance just after the edge that accepted them.
    always @(posedge px_clk_i) begin
        #1;
        if (acc0 && s0_q.size() > 0) s0_q.delete(0);
        if (acc1 && s1_q.size() > 0) s1_q.delete(0);
        if (s0_q.size() > 0) begin
            s0_tvalid = 1'b1;
            s0_tdata  = s0_q[0].data;
            s0_tuser  = s0_q[0].user;
            s0_tlast  = s0_q[0].last;
        end else begin
            s0_tvalid = 1'b0;
            s0_tuser  = 1'b0;
            s0_tlast  = 1'b0;
        end
        if (s1_q.size() > 0) begin
            s1_tvalid = 1'b1;
            s1_tdata  = s1_q[0].data;
            s1_tuser  = s1_q[0].user;
            s1_tlast  = s1_q[0].last;
        end else begin
            s1_tvalid = 1'b0;
            s1_tuser  = 1'b0;
            s1_tlast  = 1'b0;
        end
        m_tready = bp_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    always @(negedge px_clk_i) begin
        acc0 = s0_tvalid & s0_tready;
        acc1 = s1_tvalid & s1_tready;
        if (frame_err_o) err_seen++;
        if (m_tvalid && m_tready && !rst_i) begin
            out_beats++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_beat: got data=%h user=%b last=%b, required no beat",
                         m_tdata, m_tuser, m_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_tdata, m_tuser, m_tlast} !== mon_e) begin
                    n_bad++;
                    $display("[TB] FAIL out_beat: got data=%h user=%b last=%b, required data=%h user=%b last=%b",
                             m_tdata, m_tuser, m_tlast, mon_e.data, mon_e.user, mon_e.last);
                end
            end
        end
        if (park_chk) begin
            n_cmp++;
            if (s0_tready !== !(s0_tvalid & s0_tuser)) begin
                n_bad++;
                $display("[TB] FAIL park_ready: got s0_tready=%b, required %b",
                         s0_tready, !(s0_tvalid & s0_tuser));
            end
        end
    end

    function automatic logic [DW-1:0] pix(input int src, input int fid, input int ln, input int px);
        return {8'(src), 8'(fid), 8'(ln), 8'(px)};
    endfunction

    task automatic add_beat(input int src, input logic [DW-1:0] d, input logic u, input logic l,
                            input bit expect_out);
        beat_t b;
        b = '{data: d, user: u, last: l};
        if (src == 0) s0_q.push_back(b);
        else          s1_q.push_back(b);
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic add_frame(input int src, input int fid);
        for (int ln = 0; ln < YR; ln++)
            for (int px = 0; px < XR; px++)
                add_beat(src, pix(src, fid, ln, px), (ln == 0 && px == 0), (px == XR - 1), 1'b1);
    endtask

    task automatic add_junk(input int src, input int n);
        for (int i = 0; i < n; i++)
            add_beat(src, 32'hEE00_0000 + DW'(i), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_cmp++;
        if (actual !== required) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    // Waits until at most n expected beats remain; running out of budget counts as a failure.
    task automatic wait_exp_le(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() > n && cyc < budget) begin
            @(negedge px_clk_i);
            #1;
            cyc++;
        end
        if (exp_q.size() > n) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL wait_timeout: got %0d beats pending, required at most %0d", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic check_errors(input string name);
        repeat (3) @(negedge px_clk_i);
        #1;
        check_output(name, 32'(err_seen), 32'(exp_err));
    endtask

    task automatic apply_stimulus();
        // Reset values, then junk followed by one clean s0 frame.
        repeat (2) @(negedge px_clk_i);
        check_output("rst_active", 32'(active_o), 32'd0);
        check_output("rst_pending", 32'(switch_pending_o), 32'd0);
        check_output("rst_frame_err", 32'(frame_err_o), 32'd0);
        check_output("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        @(posedge px_clk_i);
        #1;
        rst_i     = 1'b0;
        out_beats = 0;
        add_junk(0, 3);
        add_frame(0, 1);
        wait_exp_le(0, 200);
        check_errors("clean_frame_err");
        check_output("clean_beat_count", 32'(out_beats), 32'd8);

        // Request s1 mid-frame; s1 junk must be drained and its SOF held until the switch.
        add_frame(0, 2);
        add_junk(1, 3);
        add_frame(1, 3);
        wait_exp_le(13, 200);
        sel_i = 1'b1;
        @(negedge px_clk_i);
        check_output("pending_after_1", 32'(switch_pending_o), 32'd0);
        @(negedge px_clk_i);
        check_output("pending_after_2", 32'(switch_pending_o), 32'd1);
        wait_exp_le(8, 200);
        check_output("active_at_eof", 32'(active_o), 32'd0);
        check_output("s1_parked_depth", 32'(s1_q.size()), 32'd8);
        check_output("s1_parked_ready", 32'(s1_tready), 32'd0);
        @(negedge px_clk_i);
        check_output("active_after_eof", 32'(active_o), 32'd1);
        wait_exp_le(0, 200);
        check_errors("switch_frame_err");

        // Random backpressure on s1 while s0 parks, then switch back to s0.
        add_frame(1, 4);
        add_junk(0, 2);
        add_frame(0, 5);
        sel_i    = 1'b0;
        bp_rand  = 1'b1;
        park_chk = 1'b1;
        wait_exp_le(10, 400);
        park_chk = 1'b0;
        wait_exp_le(0, 400);
        bp_rand  = 1'b0;
        check_errors("bp_frame_err");
        check_output("bp_active", 32'(active_o), 32'd0);
        check_output("bp_pending", 32'(switch_pending_o), 32'd0);

        // Short first line: tlast at pixel 2, then a normal second line ends the frame.
        add_beat(0, pix(0, 6, 0, 0), 1'b1, 1'b0, 1'b1);
        add_beat(0, pix(0, 6, 0, 1), 1'b0, 1'b0, 1'b1);
        add_beat(0, pix(0, 6, 0, 2), 1'b0, 1'b1, 1'b1);
        for (int px = 0; px < XR; px++)
            add_beat(0, pix(0, 6, 1, px), 1'b0, (px == XR - 1), 1'b1);
        add_junk(0, 1);
        exp_err++;
        wait_exp_le(0, 200);
        check_errors("short_line_err");

        // SOF at line 1 pixel 1 restarts the frame; a full 8 beats must follow before EOF.
        for (int px = 0; px < XR; px++)
            add_beat(0, pix(0, 7, 0, px), (px == 0), (px == XR - 1), 1'b1);
        add_beat(0, pix(0, 7, 1, 0), 1'b0, 1'b0, 1'b1);
        add_frame(0, 8);
        add_junk(0, 1);
        exp_err++;
        wait_exp_le(0, 200);
        check_errors("early_sof_err");

        // Reset mid-frame with s1 requested: s0 owns the output again until the next EOF.
        add_beat(0, pix(0, 9, 0, 0), 1'b1, 1'b0, 1'b1);
        add_beat(0, pix(0, 9, 0, 1), 1'b0, 1'b0, 1'b1);
        add_beat(0, pix(0, 9, 0, 2), 1'b0, 1'b0, 1'b1);
        wait_exp_le(0, 200);
        sel_i = 1'b1;
        @(posedge px_clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge px_clk_i);
        check_output("in_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        @(posedge px_clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge px_clk_i);
        check_output("post_rst_active", 32'(active_o), 32'd0);
        check_output("post_rst_pending", 32'(switch_pending_o), 32'd0);
        add_junk(0, 1);
        add_frame(0, 10);
        add_frame(1, 11);
        wait_exp_le(0, 300);
        check_errors("post_rst_frame_err");
        check_output("post_rst_switched", 32'(active_o), 32'd1);
    endtask

    initial begin
        apply_stimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
